i2s_ping_pong_buffer: RTL and testbench

I2S_PING_PONG_BUFFER -- requirements
Module: i2s_ping_pong_buffer

---
 rtl/i2s_ping_pong_buffer_if.sv | 25 ++
 rtl/i2s_ping_pong_buffer.sv | 123 ++++++++++++
 tb/tb_i2s_ping_pong_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_ping_pong_buffer_if.sv
// i2s_ping_pong_buffer_if: writer/reader bus of the two-bank I2S sample buffer.
// slave is the buffer side, master is the side producing and consuming samples.
interface i2s_ping_pong_buffer_if;
    logic [23:0] o_wfifo_size;
    logic [1:0]  o_wfifo_ready;
    logic [1:0]  i_wfifo_activate;
    logic        i_wfifo_strobe;
    logic [31:0] i_wfifo_data;
    logic        o_rfifo_ready;
    logic        i_rfifo_activate;
    logic [23:0] o_rfifo_size;
    logic        i_rfifo_strobe;
    logic [31:0] o_rfifo_data;
    logic        o_overflow;

    modport slave (
        output o_wfifo_size, o_wfifo_ready, o_rfifo_ready, o_rfifo_size, o_rfifo_data, o_overflow,
        input  i_wfifo_activate, i_wfifo_strobe, i_wfifo_data, i_rfifo_activate, i_rfifo_strobe
    );

    modport master (
        input  o_wfifo_size, o_wfifo_ready, o_rfifo_ready, o_rfifo_size, o_rfifo_data, o_overflow,
        output i_wfifo_activate, i_wfifo_strobe, i_wfifo_data, i_rfifo_activate, i_rfifo_strobe
    );
endinterface

// File: rtl/i2s_ping_pong_buffer.sv
// i2s_ping_pong_buffer: two-bank sample buffer; banks cycle EMPTY -> WRITING -> FULL -> READING -> EMPTY,
// and FULL banks are handed to the reader in the order they were committed.
module i2s_ping_pong_buffer #(
    parameter int ADDR_WIDTH = 6
) (
    input logic clk,
    input logic rst_n,
    i2s_ping_pong_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [23:0] DEPTH_W = 24'(DEPTH);

    typedef enum logic [1:0] {EMPTY, WRITING, FULL, READING} bank_state_e;

    bank_state_e state_q [2];
    bank_state_e state_d [2];
    logic [23:0] cnt_q [2];
    logic [23:0] cnt_d [2];
    logic [23:0] rptr_q, rptr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  wact_q, wact_d;
    logic        ract_q, ract_d;
    logic        newer_q, newer_d;
    logic        overflow_q, overflow_d;
    logic [31:0] mem [2*DEPTH];

    logic [1:0] is_empty, is_writing, is_full, is_reading;
    logic [1:0] w_rise, w_fall, claim;
    logic       r_rise, r_fall, r_start, r_ready;
    logic       w_bank, r_bank, oldest, w_ok, r_ok;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            is_empty[i]   = state_q[i] == EMPTY;
            is_writing[i] = state_q[i] == WRITING;
            is_full[i]    = state_q[i] == FULL;
            is_reading[i] = state_q[i] == READING;
        end
    end

    // Edge history resets high so activates held through reset must fall before they can claim.
    assign w_rise  = bus.i_wfifo_activate & ~wact_q;
    assign w_fall  = ~bus.i_wfifo_activate & wact_q;
    assign r_rise  = bus.i_rfifo_activate & ~ract_q;
    assign r_fall  = ~bus.i_rfifo_activate & ract_q;
    assign claim   = {w_rise[1] & ~w_rise[0] & is_empty[1], w_rise[0] & is_empty[0]};
    assign w_bank  = ~is_writing[0];
    assign r_bank  = is_reading[1];
    assign oldest  = (&is_full) ? ~newer_q : is_full[1];
    assign r_ready = (|is_full) & ~(|is_reading) & ~bus.i_rfifo_activate;
    assign r_start = r_rise & (|is_full) & ~(|is_reading);
    assign w_ok    = bus.i_wfifo_strobe & (|is_writing) & (cnt_q[w_bank] < DEPTH_W);
    assign r_ok    = bus.i_rfifo_strobe & (|is_reading) & (rptr_q < cnt_q[r_bank]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= '{EMPTY, EMPTY};
            cnt_q      <= '{24'd0, 24'd0};
            rptr_q     <= '0;
            rdata_q    <= '0;
            wact_q     <= '1;
            ract_q     <= 1'b1;
            newer_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rptr_q     <= rptr_d;
            rdata_q    <= rdata_d;
            wact_q     <= wact_d;
            ract_q     <= ract_d;
            newer_q    <= newer_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ok) mem[{w_bank, cnt_q[w_bank][ADDR_WIDTH-1:0]}] <= bus.i_wfifo_data;
    end

    always_comb begin
        newer_d    = newer_q;
        wact_d     = bus.i_wfifo_activate;
        ract_d     = bus.i_rfifo_activate;
        overflow_d = overflow_q | (bus.i_wfifo_strobe & ~w_ok);
        rdata_d    = r_ok ? mem[{r_bank, rptr_q[ADDR_WIDTH-1:0]}] : rdata_q;
        rptr_d     = r_start ? '0 : r_ok ? rptr_q + 24'd1 : rptr_q;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = (w_ok && w_bank == 1'(i)) ? cnt_q[i] + 24'd1 : cnt_q[i];
            case (state_q[i])
                EMPTY: begin
                    if (claim[i]) begin
                        state_d[i] = WRITING;
                        cnt_d[i]   = '0;
                    end
                end
                WRITING: begin
                    if (w_fall[i]) begin
                        state_d[i] = (|cnt_d[i]) ? FULL : EMPTY;
                        if (|cnt_d[i]) newer_d = 1'(i);
                    end
                end
                FULL: begin
                    if (r_start && oldest == 1'(i)) state_d[i] = READING;
                end
                default: begin
                    if (r_fall) state_d[i] = EMPTY;
                end
            endcase
        end
    end

    // Reset forces the writer view to "both banks free" even if activates are held high.
    always_comb begin
        bus.o_wfifo_size  = DEPTH_W;
        bus.o_wfifo_ready = {2{~rst_n}} | (is_empty & ~bus.i_wfifo_activate);
        bus.o_rfifo_ready = r_ready;
        bus.o_rfifo_size  = (|is_reading) ? cnt_q[r_bank] : r_ready ? cnt_q[oldest] : '0;
        bus.o_rfifo_data  = rdata_q;
        bus.o_overflow    = overflow_q;
    end
endmodule

// File: tb/tb_i2s_ping_pong_buffer.sv
// tb_i2s_ping_pong_buffer: randomized ping-pong traffic checked against a queue model
// (per-bank word lists plus a commit-order list of filled banks).
module tb_i2s_ping_pong_buffer;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] bank_q [2][$];
    int order_q [$];
    logic [31:0] last_rd = '0;

    i2s_ping_pong_buffer_if bus ();
    i2s_ping_pong_buffer #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        bank_q[0].delete();
        bank_q[1].delete();
        order_q.delete();
        last_rd = '0;
    endtask

    task automatic do_reset();
        bus.i_wfifo_activate = 2'b00;
        bus.i_wfifo_strobe = 1'b0;
        bus.i_wfifo_data = '0;
        bus.i_rfifo_activate = 1'b0;
        bus.i_rfifo_strobe = 1'b0;
        rst_n = 1'b0;
        model_clear();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic fill(input int b, input int n, input bit seq);
        logic [31:0] d;
        bus.i_wfifo_activate[b] = 1'b1;
        tick();
        bank_q[b].delete();
        for (int k = 0; k < n; k++) begin
            d = seq ? 32'(k + 1) : ($urandom & 32'h80FF_FFFF);
            bus.i_wfifo_strobe = 1'b1;
            bus.i_wfifo_data = d;
            tick();
            if (bank_q[b].size() < DEPTH) bank_q[b].push_back(d);
        end
        bus.i_wfifo_strobe = 1'b0;
        bus.i_wfifo_activate[b] = 1'b0;
        tick();
        if (bank_q[b].size() > 0) order_q.push_back(b);
    endtask

    task automatic drain(input int n);
        int b;
        int sz;
        b = order_q.pop_front();
        sz = bank_q[b].size();
        checks++;
        if (bus.o_rfifo_ready !== 1'b1 || bus.o_rfifo_size !== 24'(sz)) begin
            errors++;
            $display("FAIL offer: got ready=%b size=%0d, want ready=1 size=%0d", bus.o_rfifo_ready, bus.o_rfifo_size, sz);
        end
        bus.i_rfifo_activate = 1'b1;
        tick();
        for (int k = 0; k < n; k++) begin
            bus.i_rfifo_strobe = 1'b1;
            #2;
            checks++;
            if (bus.o_rfifo_data !== last_rd) begin
                errors++;
                $display("FAIL latency word %0d: got %h, want %h", k, bus.o_rfifo_data, last_rd);
            end
            tick();
            if (k < sz) last_rd = bank_q[b][k];
            checks++;
            if (bus.o_rfifo_data !== last_rd) begin
                errors++;
                $display("FAIL read bank %0d word %0d: got %h, want %h", b, k, bus.o_rfifo_data, last_rd);
            end
        end
        bus.i_rfifo_strobe = 1'b0;
        bus.i_rfifo_activate = 1'b0;
        tick();
        checks++;
        if (bus.o_wfifo_ready[b] !== 1'b1) begin
            errors++;
            $display("FAIL release bank %0d: got wready=%b, want bit set", b, bus.o_wfifo_ready);
        end
    endtask

    task automatic test_reset();
        bus.i_wfifo_activate = 2'b00;
        bus.i_wfifo_strobe = 1'b0;
        bus.i_wfifo_data = '0;
        bus.i_rfifo_activate = 1'b0;
        bus.i_rfifo_strobe = 1'b0;
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.o_wfifo_ready !== 2'b11 || bus.o_rfifo_ready !== 1'b0 || bus.o_rfifo_size !== 24'd0 ||
            bus.o_rfifo_data !== 32'h0 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: got wr=%b rr=%b rs=%0d rd=%h ov=%b, want 11 0 0 0 0", bus.o_wfifo_ready,
                     bus.o_rfifo_ready, bus.o_rfifo_size, bus.o_rfifo_data, bus.o_overflow);
        end
        checks++;
        if (bus.o_wfifo_size !== 24'(DEPTH)) begin
            errors++;
            $display("FAIL wfifo_size: got %0d, want %0d", bus.o_wfifo_size, DEPTH);
        end
        tick();
        rst_n = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic test_basic();
        fill(0, 10, 1'b1);
        checks++;
        if (bus.o_wfifo_ready !== 2'b10 || bus.o_rfifo_ready !== 1'b1 || bus.o_rfifo_size !== 24'd10) begin
            errors++;
            $display("FAIL basic commit: got wr=%b rr=%b rs=%0d, want 10 1 10", bus.o_wfifo_ready,
                     bus.o_rfifo_ready, bus.o_rfifo_size);
        end
        drain(10);
        checks++;
        if (bus.o_wfifo_ready !== 2'b11) begin
            errors++;
            $display("FAIL basic release: got wr=%b, want 11", bus.o_wfifo_ready);
        end
    endtask

    task automatic test_ping_pong();
        int first;
        for (int it = 0; it < 8; it++) begin
            first = int'($urandom_range(0, 1));
            fill(first, int'($urandom_range(1, DEPTH)), 1'b0);
            fill(1 - first, int'($urandom_range(1, DEPTH)), 1'b0);
            checks++;
            if (bus.o_wfifo_ready !== 2'b00) begin
                errors++;
                $display("FAIL both full: got wr=%b, want 00", bus.o_wfifo_ready);
            end
            drain(int'($urandom_range(0, bank_q[order_q[0]].size() + 2)));
            drain(int'($urandom_range(0, bank_q[order_q[0]].size() + 2)));
        end
        checks++;
        if (bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL no overflow: got %b, want 0", bus.o_overflow);
        end
    endtask

    task automatic test_dual_activate_and_empty_commit();
        logic [31:0] d;
        bus.i_wfifo_activate = 2'b11;
        tick();
        bank_q[0].delete();
        for (int k = 0; k < 3; k++) begin
            d = $urandom & 32'h80FF_FFFF;
            bus.i_wfifo_strobe = 1'b1;
            bus.i_wfifo_data = d;
            tick();
            bank_q[0].push_back(d);
        end
        bus.i_wfifo_strobe = 1'b0;
        bus.i_wfifo_activate = 2'b00;
        tick();
        order_q.push_back(0);
        checks++;
        if (bus.o_wfifo_ready !== 2'b10 || bus.o_rfifo_size !== 24'd3) begin
            errors++;
            $display("FAIL dual activate: got wr=%b rs=%0d, want 10 3", bus.o_wfifo_ready, bus.o_rfifo_size);
        end
        drain(3);
        fill(1, 0, 1'b0);
        checks++;
        if (bus.o_wfifo_ready !== 2'b11 || bus.o_rfifo_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty commit: got wr=%b rr=%b, want 11 0", bus.o_wfifo_ready, bus.o_rfifo_ready);
        end
    endtask

    task automatic test_simultaneous();
        int n0;
        int n1;
        logic [31:0] d;
        n0 = int'($urandom_range(2, DEPTH));
        n1 = int'($urandom_range(1, DEPTH));
        fill(0, n0, 1'b0);
        void'(order_q.pop_front());
        bus.i_rfifo_activate = 1'b1;
        tick();
        bus.i_rfifo_strobe = 1'b1;
        tick();
        bus.i_rfifo_strobe = 1'b0;
        last_rd = bank_q[0][0];
        bus.i_wfifo_activate[1] = 1'b1;
        tick();
        bank_q[1].delete();
        for (int k = 0; k < n1; k++) begin
            d = $urandom & 32'h80FF_FFFF;
            bus.i_wfifo_strobe = 1'b1;
            bus.i_wfifo_data = d;
            tick();
            bank_q[1].push_back(d);
        end
        bus.i_wfifo_strobe = 1'b0;
        checks++;
        if (bus.o_rfifo_ready !== 1'b0 || bus.o_rfifo_size !== 24'(n0) || bus.o_rfifo_data !== last_rd) begin
            errors++;
            $display("FAIL reading view: got rr=%b rs=%0d rd=%h, want 0 %0d %h", bus.o_rfifo_ready,
                     bus.o_rfifo_size, bus.o_rfifo_data, n0, last_rd);
        end
        bus.i_wfifo_activate[1] = 1'b0;
        bus.i_rfifo_activate = 1'b0;
        tick();
        order_q.push_back(1);
        checks++;
        if (bus.o_wfifo_ready !== 2'b01 || bus.o_rfifo_ready !== 1'b1 || bus.o_rfifo_size !== 24'(n1)) begin
            errors++;
            $display("FAIL simultaneous: got wr=%b rr=%b rs=%0d, want 01 1 %0d", bus.o_wfifo_ready,
                     bus.o_rfifo_ready, bus.o_rfifo_size, n1);
        end
        drain(n1);
    endtask

    task automatic test_overflow();
        fill(1, DEPTH + 1, 1'b0);
        checks++;
        if (bus.o_overflow !== 1'b1 || bus.o_rfifo_size !== 24'(DEPTH)) begin
            errors++;
            $display("FAIL overflow fill: got ov=%b rs=%0d, want 1 %0d", bus.o_overflow, bus.o_rfifo_size, DEPTH);
        end
        drain(DEPTH + 2);
        checks++;
        if (bus.o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow sticky: got %b, want 1", bus.o_overflow);
        end
        do_reset();
        checks++;
        if (bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow cleared: got %b, want 0", bus.o_overflow);
        end
        bus.i_wfifo_strobe = 1'b1;
        bus.i_wfifo_data = 32'h8000_0001;
        tick();
        bus.i_wfifo_strobe = 1'b0;
        checks++;
        if (bus.o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow idle strobe: got %b, want 1", bus.o_overflow);
        end
    endtask

    task automatic test_reset_mid();
        fill(0, 5, 1'b1);
        void'(order_q.pop_front());
        bus.i_rfifo_activate = 1'b1;
        tick();
        bus.i_rfifo_strobe = 1'b1;
        tick();
        bus.i_rfifo_strobe = 1'b0;
        checks++;
        if (bus.o_rfifo_data !== 32'd1) begin
            errors++;
            $display("FAIL mid read: got %h, want 1", bus.o_rfifo_data);
        end
        bus.i_wfifo_activate[1] = 1'b1;
        tick();
        bus.i_wfifo_strobe = 1'b1;
        bus.i_wfifo_data = 32'h0012_3456;
        tick();
        tick();
        bus.i_wfifo_strobe = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_wfifo_ready !== 2'b11 || bus.o_rfifo_ready !== 1'b0 || bus.o_rfifo_size !== 24'd0 ||
            bus.o_rfifo_data !== 32'h0 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL async reset: got wr=%b rr=%b rs=%0d rd=%h ov=%b, want 11 0 0 0 0", bus.o_wfifo_ready,
                     bus.o_rfifo_ready, bus.o_rfifo_size, bus.o_rfifo_data, bus.o_overflow);
        end
        model_clear();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.o_wfifo_ready !== 2'b01 || bus.o_rfifo_ready !== 1'b0 || bus.o_rfifo_size !== 24'd0) begin
            errors++;
            $display("FAIL held activates: got wr=%b rr=%b rs=%0d, want 01 0 0", bus.o_wfifo_ready,
                     bus.o_rfifo_ready, bus.o_rfifo_size);
        end
        bus.i_wfifo_strobe = 1'b1;
        tick();
        bus.i_wfifo_strobe = 1'b0;
        checks++;
        if (bus.o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL no claim after reset: got ov=%b, want 1", bus.o_overflow);
        end
        bus.i_wfifo_activate = 2'b00;
        bus.i_rfifo_activate = 1'b0;
        tick();
        checks++;
        if (bus.o_wfifo_ready !== 2'b11) begin
            errors++;
            $display("FAIL rearm: got wr=%b, want 11", bus.o_wfifo_ready);
        end
        fill(1, 3, 1'b0);
        drain(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ping_pong();
        test_dual_activate_and_empty_commit();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
